// File: rtl/sparse_mac_pe_pkg.sv
// Shared defaults and accumulate helper for the sparse MAC processing element.
package sparse_pe_pkg;

  localparam int PE_W     = 4;
  localparam int PE_ACC_W = 16;
  localparam int PE_LEN   = 9;
  // nz counter width for the default window length
  localparam int PE_NZ_W  = $clog2(PE_LEN + 1);

  // Working width of sat_add; callers sign-extend into it (ACC_W must be < SA_W).
  localparam int SA_W = 64;

  typedef struct packed {
    logic [SA_W-1:0] sum;
    logic            ovf;
  } sat_res_t;

  // Add prod to acc as an acc_w-bit signed value. Out-of-range results either
  // clamp (sat=1) or wrap (sat=0); both report ovf.
  function automatic sat_res_t sat_add(input logic signed [SA_W-1:0] acc,
                                       input logic signed [SA_W-1:0] prod,
                                       input int                     acc_w,
                                       input bit                     sat);
    logic signed [SA_W-1:0] s, hi, lo, wr;
    sat_res_t r;
    s  = acc + prod;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    wr = (s <<< (SA_W - acc_w)) >>> (SA_W - acc_w);
    r.ovf = (s > hi) || (s < lo);
    if (!r.ovf)   r.sum = s;
    else if (sat) r.sum = (s > hi) ? hi : lo;
    else          r.sum = wr;
    return r;
  endfunction

endpackage

// File: rtl/sparse_mac_pe_if.sv
// Operand stream in, window result stream out, both valid/ready.
interface sparse_mac_pe_if
  import sparse_pe_pkg::*;
#(
  parameter int W     = PE_W,
  parameter int ACC_W = PE_ACC_W,
  parameter int LEN   = PE_LEN
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic signed [W-1:0]        in_a;
  logic signed [W-1:0]        in_b;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    out_acc;
  logic [$clog2(LEN+1)-1:0]   out_nz;
  logic                       out_ovf;

  // PE side
  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_nz, out_ovf
  );

  // producer/consumer side
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_nz, out_ovf
  );
endinterface

// File: rtl/sparse_mac_pe_umag_mult.sv
// W x W unsigned magnitude multiplier, combinational, 2W-bit product.
module umag_mult #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  if (W <= 4) begin : g_lut
    // Small operands: exhaustive product table, one entry per (a,b) pair.
    always_comb begin
      p_o = '0;
      for (int i = 0; i < (1 << W); i++)
        for (int j = 0; j < (1 << W); j++)
          if (a_i == W'(i) && b_i == W'(j)) p_o = (2*W)'(i * j);
    end
  end else begin : g_mul
    assign p_o = (2*W)'(a_i) * (2*W)'(b_i);
  end
endmodule

// File: rtl/sparse_mac_pe.sv
// Pipelined signed MAC PE with zero skipping: S1 sign/magnitude split,
// S2 gated magnitude multiply, S3 accumulate into a per-window result.
module sparse_mac_pe
  import sparse_pe_pkg::*;
#(
  parameter int W     = PE_W,
  parameter int ACC_W = PE_ACC_W,
  parameter int LEN   = PE_LEN,
  parameter bit SAT   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  sparse_mac_pe_if.slave bus
);
  localparam int NZ_W   = $clog2(LEN + 1);
  localparam int IDX_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int STAGES = 1;

  logic                    stall, accept, elem_last, s3_fire;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [STAGES:0]         vld_pipe_q, vld_pipe_d;   // [0]=S1 valid, [1]=S2 valid

  logic                    s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d, s1_last_q, s1_last_d;
  logic [W-1:0]            s1_amag_q, s1_amag_d, s1_bmag_q, s1_bmag_d;

  logic signed [ACC_W-1:0] s2_prod_q, s2_prod_d;
  logic                    s2_nz_q, s2_nz_d, s2_last_q, s2_last_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [NZ_W-1:0]         nz_q, nz_d;
  logic                    ovf_q, ovf_d;

  logic                    out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [NZ_W-1:0]         out_nz_q, out_nz_d;

  logic [W-1:0]            mult_a, mult_b;
  logic [2*W-1:0]          mag_p;
  logic signed [ACC_W-1:0] mag_ext, prod;
  sat_res_t                sa;
  logic signed [ACC_W-1:0] sum;
  logic [NZ_W-1:0]         nz_inc;
  logic                    sum_unused;

  // A held result freezes the whole pipe, even if no window end is in flight.
  assign stall     = out_valid_q & ~bus.out_ready;
  assign accept    = bus.in_valid & ~stall;
  assign elem_last = (idx_q == IDX_W'(LEN - 1)) | bus.in_last;
  assign s3_fire   = ~stall & vld_pipe_q[1];

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_nz    = out_nz_q;
  assign bus.out_ovf   = out_ovf_q;

  // Zero operands keep the multiplier inputs at 0.
  assign mult_a = s1_zero_q ? '0 : s1_amag_q;
  assign mult_b = s1_zero_q ? '0 : s1_bmag_q;

  umag_mult #(.W(W)) u_mult (
    .a_i (mult_a),
    .b_i (mult_b),
    .p_o (mag_p)
  );

  assign mag_ext = ACC_W'(mag_p);
  assign prod    = s1_sign_q ? -mag_ext : mag_ext;

  assign sa         = sat_add(SA_W'(acc_q), SA_W'(s2_prod_q), ACC_W, SAT);
  assign sum        = sa.sum[ACC_W-1:0];
  assign sum_unused = ^sa.sum[SA_W-1:ACC_W];
  assign nz_inc     = nz_q + NZ_W'(s2_nz_q);

  // Window index advances per accepted element and wraps on a tagged last.
  always_comb begin
    idx_d = idx_q;
    if (accept) idx_d = elem_last ? '0 : idx_q + 1'b1;
  end

  // S1/S2 next state and the valid shift register; everything holds on stall.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_sign_d  = s1_sign_q;
    s1_amag_d  = s1_amag_q;
    s1_bmag_d  = s1_bmag_q;
    s1_zero_d  = s1_zero_q;
    s1_last_d  = s1_last_q;
    s2_prod_d  = s2_prod_q;
    s2_nz_d    = s2_nz_q;
    s2_last_d  = s2_last_q;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], accept};
      s1_sign_d  = bus.in_a[W-1] ^ bus.in_b[W-1];
      // |-2^(W-1)| comes out as the unsigned pattern 2^(W-1), which is correct.
      s1_amag_d  = bus.in_a[W-1] ? (~bus.in_a + 1'b1) : bus.in_a;
      s1_bmag_d  = bus.in_b[W-1] ? (~bus.in_b + 1'b1) : bus.in_b;
      s1_zero_d  = (bus.in_a == '0) | (bus.in_b == '0);
      s1_last_d  = elem_last;
      s2_prod_d  = prod;
      s2_nz_d    = ~s1_zero_q;
      s2_last_d  = s1_last_q;
    end
  end

  // Accumulate; a last-tagged product publishes the window and restarts it.
  always_comb begin
    acc_d       = acc_q;
    nz_d        = nz_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_nz_d    = out_nz_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    if (s3_fire) begin
      if (s2_last_q) begin
        out_acc_d   = sum;
        out_nz_d    = nz_inc;
        out_ovf_d   = ovf_q | sa.ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        nz_d        = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum;
        nz_d  = nz_inc;
        ovf_d = ovf_q | sa.ovf;
      end
    end
  end

  // State registers; reset discards any partial window in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      vld_pipe_q  <= '0;
      s1_sign_q   <= 1'b0;
      s1_amag_q   <= '0;
      s1_bmag_q   <= '0;
      s1_zero_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      s2_nz_q     <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      nz_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_nz_q    <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      vld_pipe_q  <= vld_pipe_d;
      s1_sign_q   <= s1_sign_d;
      s1_amag_q   <= s1_amag_d;
      s1_bmag_q   <= s1_bmag_d;
      s1_zero_q   <= s1_zero_d;
      s1_last_q   <= s1_last_d;
      s2_prod_q   <= s2_prod_d;
      s2_nz_q     <= s2_nz_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      nz_q        <= nz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_nz_q    <= out_nz_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sparse_mac_pe.sv
// Three PEs (16-bit sat, 8-bit sat, 8-bit wrap) share one stimulus stream and
// are scored against a window-level arithmetic model.
module tb_sparse_mac_pe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, in_valid, in_last, out_ready;
  logic signed [3:0] in_a, in_b;

  sparse_mac_pe_if #(.W(4), .ACC_W(16), .LEN(9)) if0 ();
  sparse_mac_pe_if #(.W(4), .ACC_W(8),  .LEN(9)) if1 ();
  sparse_mac_pe_if #(.W(4), .ACC_W(8),  .LEN(9)) if2 ();

  sparse_mac_pe #(.W(4), .ACC_W(16), .LEN(9), .SAT(1'b1)) d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sparse_mac_pe #(.W(4), .ACC_W(8),  .LEN(9), .SAT(1'b1)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sparse_mac_pe #(.W(4), .ACC_W(8),  .LEN(9), .SAT(1'b0)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_a = in_a;          assign if1.in_a = in_a;          assign if2.in_a = in_a;
  assign if0.in_b = in_b;          assign if1.in_b = in_b;          assign if2.in_b = in_b;
  assign if0.in_last = in_last;    assign if1.in_last = in_last;    assign if2.in_last = in_last;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  logic o_vld[3], o_rdy[3], o_ovf[3];
  int   o_acc[3], o_nz[3];
  assign o_vld[0] = if0.out_valid; assign o_vld[1] = if1.out_valid; assign o_vld[2] = if2.out_valid;
  assign o_rdy[0] = if0.in_ready;  assign o_rdy[1] = if1.in_ready;  assign o_rdy[2] = if2.in_ready;
  assign o_ovf[0] = if0.out_ovf;   assign o_ovf[1] = if1.out_ovf;   assign o_ovf[2] = if2.out_ovf;
  assign o_acc[0] = int'(if0.out_acc); assign o_acc[1] = int'(if1.out_acc); assign o_acc[2] = int'(if2.out_acc);
  assign o_nz[0]  = int'(if0.out_nz);  assign o_nz[1]  = int'(if1.out_nz);  assign o_nz[2]  = int'(if2.out_nz);

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint acc; int nz; bit ovf; int edge_n; bit lat; } exp_t;
  exp_t   expq[3][$];
  int     accw[3] = '{16, 8, 8};
  bit     satm[3] = '{1'b1, 1'b1, 1'b0};
  longint win[$];
  int     widx = 0;
  bit     started = 0, lat_chk = 0, soak_done = 0;
  bit     held[3];
  int     p_acc[3], p_nz[3];
  logic   p_ovf[3];
  int     last_acc[3], last_nz[3], res_cnt[3];
  bit     last_ovf[3];
  int     hist0[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Window result from plain integer arithmetic: per-step clamp or modulo.
  function automatic exp_t model(input int k);
    exp_t   r;
    longint hi, lo, acc, s, md;
    hi = (longint'(1) <<< (accw[k] - 1)) - 1;
    lo = -hi - 1;
    md = longint'(1) <<< accw[k];
    acc = 0; r.nz = 0; r.ovf = 0;
    foreach (win[i]) begin
      s = acc + win[i];
      if (win[i] != 0) r.nz++;
      if (s > hi || s < lo) begin
        r.ovf = 1;
        if (satm[k]) acc = (s > hi) ? hi : lo;
        else begin
          acc = s % md;
          if (acc < 0) acc += md;
          if (acc > hi) acc -= md;
        end
      end else acc = s;
    end
    r.acc = acc; r.edge_n = cyc + 1; r.lat = lat_chk;
    return r;
  endfunction

  // Per-cycle compare and model update, sampled mid-cycle for the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready_rule[%0d]", k), o_rdy[k], !(o_vld[k] && !out_ready));
        if (rst_n) begin
          if (held[k]) begin
            chk($sformatf("hold_valid[%0d]", k), o_vld[k], 1);
            chk($sformatf("hold_acc[%0d]", k), o_acc[k], p_acc[k]);
            chk($sformatf("hold_nz[%0d]", k), o_nz[k], p_nz[k]);
            chk($sformatf("hold_ovf[%0d]", k), o_ovf[k], p_ovf[k]);
          end
          if (o_vld[k] && out_ready) begin
            chk($sformatf("result_expected[%0d]", k), expq[k].size() > 0, 1);
            if (expq[k].size() > 0) begin
              e = expq[k].pop_front();
              chk($sformatf("out_acc[%0d]", k), o_acc[k], e.acc);
              chk($sformatf("out_nz[%0d]", k), o_nz[k], e.nz);
              chk($sformatf("out_ovf[%0d]", k), o_ovf[k], e.ovf);
              if (e.lat) chk($sformatf("latency[%0d]", k), cyc - e.edge_n, 2);
            end
            last_acc[k] = o_acc[k]; last_nz[k] = o_nz[k]; last_ovf[k] = o_ovf[k];
            res_cnt[k]++;
            if (k == 0) hist0.push_back(o_acc[0]);
          end
          held[k] = o_vld[k] && !out_ready;
          p_acc[k] = o_acc[k]; p_nz[k] = o_nz[k]; p_ovf[k] = o_ovf[k];
        end else begin
          held[k] = 0;
          expq[k].delete();
        end
      end
      if (!rst_n) begin
        win.delete(); widx = 0;
      end else if (in_valid && o_rdy[0]) begin
        win.push_back(longint'(in_a) * longint'(in_b));
        widx++;
        if (widx == 9 || in_last) begin
          for (int k = 0; k < 3; k++) expq[k].push_back(model(k));
          win.delete(); widx = 0;
        end
      end
    end
  end

  task automatic send(input int a, input int b, input bit last);
    bit done; int t;
    in_valid = 1; in_a = 4'(a); in_b = 4'(b); in_last = last;
    done = 0; t = 0;
    while (!done && t < 400) begin
      @(negedge clk); done = (o_rdy[0] === 1'b1);
      @(posedge clk); #1;
      if (!done) t++;
    end
    if (!done) chk("send_accept_timeout", t, 0);
    in_valid = 0; in_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int rnd_op();
    int r;
    r = int'($urandom_range(0, 4));
    if (r == 0) return 0;
    if (r == 1) return -8;
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  task automatic res3(input string nm, input int a0, input int n0, input bit f0,
                      input int a1, input int n1, input bit f1,
                      input int a2, input int n2, input bit f2);
    chk({nm, "_acc0"}, last_acc[0], a0); chk({nm, "_nz0"}, last_nz[0], n0); chk({nm, "_ovf0"}, last_ovf[0], f0);
    chk({nm, "_acc1"}, last_acc[1], a1); chk({nm, "_nz1"}, last_nz[1], n1); chk({nm, "_ovf1"}, last_ovf[1], f1);
    chk({nm, "_acc2"}, last_acc[2], a2); chk({nm, "_nz2"}, last_nz[2], n2); chk({nm, "_ovf2"}, last_ovf[2], f2);
  endtask

  task automatic check_reset_state(input string nm);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_valid[%0d]", nm, k), o_vld[k], 0);
      chk($sformatf("%s_acc[%0d]", nm, k), o_acc[k], 0);
      chk($sformatf("%s_nz[%0d]", nm, k), o_nz[k], 0);
      chk($sformatf("%s_ovf[%0d]", nm, k), o_ovf[k], 0);
      chk($sformatf("%s_in_ready[%0d]", nm, k), o_rdy[k], 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c0;
    rst_n = 0; in_valid = 0; in_last = 0; in_a = 0; in_b = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check_reset_state("reset");
    started = 1;

    // dense positive window, latency 2
    lat_chk = 1;
    c0 = res_cnt[0];
    repeat (9) send(7, 7, 0);
    idle(4);
    chk("t1_results", res_cnt[0] - c0, 1);
    res3("t1", 441, 9, 0, 127, 9, 1, -71, 9, 1);

    // back-to-back windows, no bubble
    t0 = cyc;
    repeat (9) send(-8, -8, 0);
    repeat (9) send(-8, 7, 0);
    chk("t2_no_bubble_cycles", cyc - t0, 18);
    idle(4);
    chk("t2_first_window", hist0[hist0.size() - 2], 576);
    chk("t2_second_window", hist0[hist0.size() - 1], -504);

    // sparse window, then early close, then idx restart
    for (int i = 0; i < 9; i++) if (i % 2 == 0) send(0, 5, 0); else send(3, -2, 0);
    idle(4);
    res3("t3_sparse", -24, 4, 0, -24, 4, 0, -24, 4, 0);
    send(0, 5, 0); send(3, -2, 0); send(0, 5, 1);
    idle(4);
    res3("t3_early", -6, 1, 0, -6, 1, 0, -6, 1, 0);
    repeat (9) send(1, 1, 0);
    idle(4);
    res3("t3_restart", 9, 9, 0, 9, 9, 0, 9, 9, 0);

    // backpressure across two windows
    lat_chk = 0;
    out_ready = 0;
    c0 = res_cnt[0];
    fork
      begin
        for (int i = 0; i < 18; i++) send(rnd_op(), rnd_op(), 0);
      end
      begin
        idle(30);
        @(negedge clk);
        chk("t4_in_ready_low", o_rdy[0], 0);
        chk("t4_out_valid_held", o_vld[0], 1);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    idle(6);
    chk("t4_two_results", res_cnt[0] - c0, 2);
    lat_chk = 1;

    // reset discards a partial window
    for (int i = 0; i < 5; i++) send(rnd_op(), rnd_op(), 0);
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    check_reset_state("mid_reset");
    repeat (9) send(1, 1, 0);
    idle(4);
    res3("t5_after_reset", 9, 9, 0, 9, 9, 0, 9, 9, 0);

    // randomized soak with gaps, early closes and random backpressure
    lat_chk = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle(int'($urandom_range(0, 2)));
          send(rnd_op(), rnd_op(), $urandom_range(0, 7) == 0);
        end
        soak_done = 1;
      end
      begin
        while (!soak_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    idle(10);
    for (int k = 0; k < 3; k++) chk($sformatf("soak_drained[%0d]", k), expq[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sparse_mac_pe.md
# sparse_mac_pe

Pipelined signed multiply-accumulate processing element for the 4-bit sparse CNN datapath; the parametrised successor of the 3x3 unsigned LUT multiplier. It accepts a stream of two's-complement activation/weight pairs and skips zero operands without driving the multiplier. It accumulates one kernel window (default 9 products, 3x3) and returns the window sum, a nonzero-product count and an overflow flag over a valid/ready handshake with backpressure.

## Interface
- W, 4: operand width, signed two's complement
- ACC_W, 16: accumulator/result width, signed; must be >= 2W
- LEN, 9: products per window
- SAT, 1: 1 = saturating accumulation, 0 = wrap-around
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input pair valid
- in_ready  out  1  PE can accept
- in_a  in  W  activation, signed
- in_b  in  W  weight, signed
- in_last  in  1  closes the window early on this element
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  signed window sum
- out_nz  out  $clog2(LEN+1)  nonzero products in window
- out_ovf  out  1  saturation/wrap occurred in window

## Operation
- Accept on in_valid & in_ready. in_ready = ~stall, with stall = out_valid & ~out_ready.
- Stall freezes all stages and the window counter. This is deliberately conservative: the pipeline stalls even with no window end in flight.
- Window counter idx, 0..LEN-1, increments per accepted element.
- An element is tagged last when idx == LEN-1 or in_last. idx then returns to 0. in_last at idx == LEN-1 is a single close, not two.
- S1 register: sign = a[W-1]^b[W-1]; |a|, |b| as W-bit unsigned (|-2^(W-1)| = 2^(W-1) fits); zero = (a==0)|(b==0); last tag.
- S2 register: product magnitude 2W bits from umag_mult, then signed and extended to ACC_W. If zero, the multiplier inputs are gated to 0 and the product is 0 with the nonzero flag clear.
- S3 accumulate: sum = acc + prod. With SAT=1, clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. With SAT=0, wrap. Either event sets the sticky ovf. nz increments for nonzero products.
- On a last-tagged product, load out_acc/out_nz/out_ovf with the final values including that product, set out_valid, and clear acc, nz and ovf to 0 in the same edge.
- Output register holds until out_valid & out_ready. Simultaneous drain and new last-product load is legal: the new result replaces the old one and out_valid stays 1.
- Reset (rst_n low at edge): all stages, idx, acc, nz, ovf and out_* cleared, and out_valid=0. A partial window in flight is discarded. in_ready=1 the cycle after release.
- Reset values: out_valid 0, out_acc 0, out_nz 0, out_ovf 0, in_ready 1.

## Timing
- Last element accepted at edge k: S1 at k, S2 at k+1, output register at k+2. out_valid is visible in the cycle after edge k+2.
- Throughput is 1 element/cycle while out_ready stays high. Back-to-back windows need no bubble.
- Stall is evaluated combinationally from registered out_valid and input out_ready. There is no combinational path from in_valid to in_ready.
- in_ready drops in the same cycle out_valid & ~out_ready holds and returns in the cycle out_ready is high.

## Structure
- Shared package sparse_pe_pkg holds:
  - defaults PE_W=4, PE_ACC_W=16, PE_LEN=9;
  - a function sat_add(acc, prod, ACC_W) returning sum and overflow;
  - a localparam for the nz counter width.
- One sub-module, umag_mult: combinational W x W unsigned magnitude multiplier, 2W-bit output. It generalises the 3x3 LUT and is a case table for W <= 4, `*` otherwise.
- The top holds the counter, the three pipeline registers, the output register and the handshake logic.

## Test plan
- W=4, LEN=9, out_ready=1: nine pairs (7,7) -> out_acc=441, out_nz=9, out_ovf=0, out_valid 2 cycles after last accept.
- Nine pairs (-8,-8) -> out_acc=576. Next window of nine (-8,7) back-to-back -> out_acc=-504, with no idle cycle between windows.
- ACC_W=8, SAT=1: nine (7,7) -> out_acc=127, out_ovf=1. SAT=0 gives the same stimulus 441 mod 256 as signed = -71, out_ovf=1.
- Sparse window alternating (0,5),(3,-2): (3,-2) lands at idx 1,3,5,7, giving four -6 products -> out_acc=-24, out_nz=4. in_last on the 3rd element (0,5),(3,-2),(0,5) -> out_acc=-6, out_nz=1, then idx restarts at 0.
- out_ready=0 while two windows are streamed -> first result held stable, in_ready=0 while out_valid is held. Raising out_ready drains both results in order with none lost or duplicated.
- rst_n low for 1 cycle after 5 accepted elements -> outputs 0, out_valid 0. A fresh nine (1,1) window afterwards -> out_acc=9, proving the partial sum was discarded.
